util_dac_cfifo: RTL
===================

UTIL_DAC_CFIFO -- requirements
Module: util_dac_cfifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, giving the sample beat width (4 lanes x 32 bit).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, giving buffer depth 2^ADDR_WIDTH beats.
REQ-003 SHALL have port clk  in  1  single clock for all logic.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port dma_xfer_req  in  1  DMA transfer request; a rising edge re-arms loading.
REQ-006 SHALL have ports dma_valid in 1, dma_data in DATA_WIDTH and dma_last in 1, forming the DMA beat stream.
REQ-007 SHALL have port dma_ready  out  1  beat accepted when dma_valid and dma_ready are both high.
REQ-008 SHALL have port dac_valid  in  1  DAC sample-request strobe.
REQ-009 SHALL have port dac_data  out  DATA_WIDTH  sample to the JESD TX link layer.
REQ-010 SHALL have port dac_fifo_bypass  in  1  stream mode, DMA forwarded straight to the DAC.
REQ-011 SHALL have port dac_underflow  out  1  one-cycle pulse per unserved request.
REQ-012 SHALL have port dac_play  out  1  high while in PLAY.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD and PLAY.
REQ-014 IDLE: dma_ready=1; an accepted beat SHALL write address 0 and move the FSM to LOAD.
REQ-015 LOAD: dma_ready=1; each accepted beat SHALL write at waddr, then waddr+1.
REQ-016 An accepted beat with dma_last=1, or written at address 2^ADDR_WIDTH-1, SHALL latch last_addr=waddr and move the FSM to PLAY on the next cycle.
REQ-017 PLAY: dma_ready=0; each dac_valid SHALL read mem[raddr].
REQ-018 Read data SHALL appear on dac_data exactly 1 cycle after dac_valid; dac_data SHALL hold between requests.
REQ-019 raddr SHALL start at 0 on entry to PLAY and wrap from last_addr to 0; a single-beat buffer (last_addr=0) SHALL repeat that beat.
REQ-020 A rising edge of dma_xfer_req in PLAY SHALL return the FSM to IDLE.
REQ-021 A dma_xfer_req edge in the same cycle as a dac_valid read SHALL still complete that read, then go to IDLE.
REQ-022 dac_valid in IDLE or LOAD (not bypass) SHALL drive dac_data=0 on the next cycle and pulse dac_underflow.
REQ-023 Bypass=1: the FSM SHALL be forced to IDLE and dma_ready SHALL equal dac_valid (combinational).
REQ-024 Bypass=1: on dac_valid, dac_data SHALL be registered to dma_data if dma_valid=1, else to 0 with a dac_underflow pulse.
REQ-025 Bypass=1: memory SHALL NOT be written.
REQ-026 Bypass deassert SHALL resume in IDLE, with stale buffer contents ignored.
REQ-027 dac_play SHALL equal (state==PLAY) && !dac_fifo_bypass.

Reset
REQ-028 resetn low SHALL force, asynchronously: state=IDLE, waddr=raddr=last_addr=0, dac_data=0, dac_underflow=0, dac_play=0, dma_xfer_req edge register=0.
REQ-029 During reset, dma_ready SHALL be 0.
REQ-030 Reset mid-LOAD or mid-PLAY SHALL discard the buffer; no memory clear is required.

Configuration
REQ-031 With UTIL_DAC_CFIFO_UNDERFLOW_CNT_EN defined, the block SHALL add output port dac_underflow_count [15:0].
REQ-032 dac_underflow_count SHALL increment on each dac_underflow pulse, saturate at 16'hFFFF, clear on reset and clear on each IDLE->LOAD transition.
REQ-033 Without UTIL_DAC_CFIFO_UNDERFLOW_CNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-034 Package util_dac_cfifo_pkg SHALL hold the state enum (IDLE/LOAD/PLAY) and the underflow-counter width constant (16).
REQ-035 Sub-module util_dac_cfifo_mem SHALL be a simple dual-port RAM, DATA_WIDTH x 2^ADDR_WIDTH, with registered 1-cycle read and no reset on the array.

Verification
REQ-036 Load: 4 beats 0x1..0x4, last on 4th; then dac_valid held high -> dac_data 1,2,3,4,1,2... starting 1 cycle after the first dac_valid; dac_play=1.
REQ-037 Single-beat load 0xAA with last -> every dac_valid returns 0xAA.
REQ-038 dac_valid during LOAD -> dac_data=0, dac_underflow pulses; with UTIL_DAC_CFIFO_UNDERFLOW_CNT_EN, 3 such requests give count=3.
REQ-039 2^ADDR_WIDTH beats without last -> forced PLAY, wrap at 1023 to 0 (default).
REQ-040 Bypass=1 in PLAY with dma_valid=1, data 0x55 -> state IDLE, dma_ready follows dac_valid, dac_data=0x55 next cycle; with dma_valid=0 -> 0 plus underflow.
REQ-041 resetn low mid-PLAY, then dma_xfer_req rise and 2-beat reload -> outputs 0 during reset, playback of the new 2 beats only.

Source files
------------

// File: rtl/util_dac_cfifo_pkg.sv
// Shared types and constants for the DAC cyclic FIFO.
package util_dac_cfifo_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StPlay = 2'd2
    } cfifo_state_e;

    localparam int unsigned UnderflowCntWidth = 16;

    function automatic logic [UnderflowCntWidth-1:0] sat_inc(
        input logic [UnderflowCntWidth-1:0] value
    );
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/util_dac_cfifo_mem.sv
// Simple dual-port RAM with a registered one-cycle read; the array has no reset.
module util_dac_cfifo_mem #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [Depth];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read port holds its last value until the next read strobe.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/util_dac_cfifo.sv
// DAC cyclic FIFO: loads one DMA buffer, then replays it to the DAC until re-armed.
// Optional underflow counter port enabled by UTIL_DAC_CFIFO_UNDERFLOW_CNT_EN.
module util_dac_cfifo
    import util_dac_cfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         dma_xfer_req,
    input  logic                         dma_valid,
    input  logic [DATA_WIDTH-1:0]        dma_data,
    input  logic                         dma_last,
    output logic                         dma_ready,
    input  logic                         dac_valid,
    output logic [DATA_WIDTH-1:0]        dac_data,
    input  logic                         dac_fifo_bypass,
    output logic                         dac_underflow,
    output logic                         dac_play
`ifdef UTIL_DAC_CFIFO_UNDERFLOW_CNT_EN
    ,
    output logic [UnderflowCntWidth-1:0] dac_underflow_count
`endif
);

    cfifo_state_e          state_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [ADDR_WIDTH-1:0] raddr_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic                  xfer_req_q;
    logic                  src_mem_q;
    logic                  underflow_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] mem_rdata;

    logic                  xfer_req_rise;
    logic                  dma_accept;
    logic                  mem_rd;
    logic [ADDR_WIDTH-1:0] mem_waddr;

    assign xfer_req_rise = dma_xfer_req & ~xfer_req_q;
    assign dma_accept    = dma_valid & dma_ready & ~dac_fifo_bypass;
    assign mem_rd        = dac_valid & ~dac_fifo_bypass & (state_q == StPlay);
    assign mem_waddr     = (state_q == StIdle) ? '0 : waddr_q;

    always_comb begin
        dma_ready = 1'b0;
        if (!resetn) begin
            dma_ready = 1'b0;
        end else if (dac_fifo_bypass) begin
            dma_ready = dac_valid;
        end else begin
            dma_ready = (state_q != StPlay);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            waddr_q     <= '0;
            raddr_q     <= '0;
            last_addr_q <= '0;
            xfer_req_q  <= 1'b0;
            src_mem_q   <= 1'b0;
            underflow_q <= 1'b0;
            out_q       <= '0;
        end else begin
            xfer_req_q  <= dma_xfer_req;
            underflow_q <= 1'b0;
            if (dac_fifo_bypass) begin
                state_q <= StIdle;
                waddr_q <= '0;
                if (dac_valid) begin
                    src_mem_q   <= 1'b0;
                    out_q       <= dma_valid ? dma_data : '0;
                    underflow_q <= ~dma_valid;
                end
            end else begin
                // Requests outside PLAY have no buffered sample to serve.
                if (dac_valid && (state_q != StPlay)) begin
                    src_mem_q   <= 1'b0;
                    out_q       <= '0;
                    underflow_q <= 1'b1;
                end
                if (mem_rd) begin
                    src_mem_q <= 1'b1;
                end
                unique case (state_q)
                    StIdle: begin
                        if (dma_accept) begin
                            waddr_q <= mem_waddr + 1'b1;
                            if (dma_last) begin
                                last_addr_q <= '0;
                                raddr_q     <= '0;
                                state_q     <= StPlay;
                            end else begin
                                state_q <= StLoad;
                            end
                        end
                    end
                    StLoad: begin
                        if (dma_accept) begin
                            waddr_q <= waddr_q + 1'b1;
                            if (dma_last || (waddr_q == '1)) begin
                                last_addr_q <= waddr_q;
                                raddr_q     <= '0;
                                state_q     <= StPlay;
                            end
                        end
                    end
                    StPlay: begin
                        if (mem_rd) begin
                            raddr_q <= (raddr_q == last_addr_q) ? '0 : raddr_q + 1'b1;
                        end
                        if (xfer_req_rise) begin
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    util_dac_cfifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk_i  (clk),
        .wr_en_i(dma_accept),
        .waddr_i(mem_waddr),
        .wdata_i(dma_data),
        .rd_en_i(mem_rd),
        .raddr_i(raddr_q),
        .rdata_o(mem_rdata)
    );

    // The RAM output is unreset, so zero/bypass samples come from out_q instead.
    assign dac_data      = src_mem_q ? mem_rdata : out_q;
    assign dac_underflow = underflow_q;
    assign dac_play      = (state_q == StPlay) && !dac_fifo_bypass;

`ifdef UTIL_DAC_CFIFO_UNDERFLOW_CNT_EN
    logic [UnderflowCntWidth-1:0] underflow_cnt_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underflow_cnt_q <= '0;
        end else if ((state_q == StIdle) && dma_accept) begin
            underflow_cnt_q <= '0;
        end else if (underflow_q) begin
            underflow_cnt_q <= sat_inc(underflow_cnt_q);
        end
    end

    assign dac_underflow_count = underflow_cnt_q;
`endif

endmodule
